// File: rtl/pcx_cpx_responder.sv
// PCX/CPX fabric endpoint for one SPARC core: request capture, FIFO, post-accept grants and CPX return.
// Optional build macro IOP_PCX_ATOM_HOLD_EN: withhold an atomic first half until its partner is queued.
module pcx_cpx_responder #(
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic         gclk,
    input  logic         reset_l,
    input  logic [4:0]   spc_pcx_req_pq,
    input  logic         spc_pcx_atom_pq,
    input  logic [123:0] spc_pcx_data_pa,
    output logic [4:0]   pcx_spc_grant_px,
    output logic         pcx_out_valid,
    input  logic         pcx_out_ready,
    output logic [123:0] pcx_out_data,
    output logic [4:0]   pcx_out_dest,
    output logic         pcx_out_atom,
    input  logic         cpx_in_valid,
    output logic         cpx_in_ready,
    input  logic [144:0] cpx_in_data,
    output logic         cpx_spc_data_rdy_cx2,
    output logic [144:0] cpx_spc_data_cx2,
    output logic [1:0]   pcx_err
);

    typedef logic [FIFO_AW:0]   ptr_t;
    typedef logic [FIFO_AW-1:0] idx_t;

    // Capture pipeline: destination/atom from PQ, data arrives one cycle later.
    logic         cap_vld_q, cap_vld_d;
    logic [4:0]   cap_dest_q, cap_dest_d;
    logic         cap_atom_q, cap_atom_d;

    ptr_t         wr_ptr_q, wr_ptr_d;
    ptr_t         rd_ptr_q, rd_ptr_d;
    logic [1:0]   err_q, err_d;
    logic [4:0]   grant_q, grant_d;

    logic         cpx_rdy_q, cpx_rdy_d;
    logic         cpx_vld_q, cpx_vld_d;
    logic [144:0] cpx_data_q, cpx_data_d;

    logic [123:0] mem_data [FIFO_DEPTH];
    logic [4:0]   mem_dest [FIFO_DEPTH];
    logic         mem_atom [FIFO_DEPTH];
`ifdef IOP_PCX_ATOM_HOLD_EN
    logic         mem_rel  [FIFO_DEPTH];
    logic         head_rel;
`endif

    ptr_t         count;
    idx_t         wr_idx, rd_idx, last_idx;
    logic         empty, full;
    logic         push_ok, overflow, pop;
    logic         head_hold, multi_hot, cpx_accept;
    logic [123:0] head_data;
    logic [4:0]   head_dest;
    logic         head_atom;

    always_comb begin
        wr_idx    = wr_ptr_q[FIFO_AW-1:0];
        rd_idx    = rd_ptr_q[FIFO_AW-1:0];
        last_idx  = wr_idx - idx_t'(1);
        count     = wr_ptr_q - rd_ptr_q;
        empty     = (count == '0);
        full      = (count == ptr_t'(FIFO_DEPTH));
        head_data = mem_data[rd_idx];
        head_dest = mem_dest[rd_idx];
        head_atom = mem_atom[rd_idx];
`ifdef IOP_PCX_ATOM_HOLD_EN
        head_rel  = mem_rel[rd_idx];
        head_hold = head_atom & ~head_rel & (count < ptr_t'(2));
`else
        head_hold = 1'b0;
`endif
    end

    always_comb begin
        cap_vld_d  = |spc_pcx_req_pq;
        cap_dest_d = spc_pcx_req_pq;
        cap_atom_d = spc_pcx_atom_pq;
        multi_hot  = (spc_pcx_req_pq & (spc_pcx_req_pq - 5'd1)) != '0;

        push_ok    = cap_vld_q & ~full;
        overflow   = cap_vld_q & full;

        pcx_out_valid = ~empty & ~head_hold;
        pop           = pcx_out_valid & pcx_out_ready;

        wr_ptr_d = push_ok ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        grant_d  = pop ? head_dest : '0;
        err_d    = err_q | {multi_hot, overflow};

        cpx_rdy_d  = 1'b1;
        cpx_accept = cpx_in_valid & cpx_rdy_q;
        cpx_vld_d  = cpx_accept;
        cpx_data_d = cpx_accept ? cpx_in_data : '0;

        // Head fields are forced to zero while empty so reset presents all-zero outputs.
        pcx_out_data = empty ? '0 : head_data;
        pcx_out_dest = empty ? '0 : head_dest;
        pcx_out_atom = empty ? 1'b0 : head_atom;

        pcx_spc_grant_px     = grant_q;
        pcx_err              = err_q;
        cpx_in_ready         = cpx_rdy_q;
        cpx_spc_data_rdy_cx2 = cpx_vld_q;
        cpx_spc_data_cx2     = cpx_data_q;
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            cap_vld_q  <= 1'b0;
            cap_dest_q <= '0;
            cap_atom_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= '0;
            grant_q    <= '0;
            cpx_rdy_q  <= 1'b0;
            cpx_vld_q  <= 1'b0;
            cpx_data_q <= '0;
        end else begin
            cap_vld_q  <= cap_vld_d;
            cap_dest_q <= cap_dest_d;
            cap_atom_q <= cap_atom_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
            grant_q    <= grant_d;
            cpx_rdy_q  <= cpx_rdy_d;
            cpx_vld_q  <= cpx_vld_d;
            cpx_data_q <= cpx_data_d;
        end
    end

    // Storage is not reset; entries are only read between the pointers.
    always_ff @(posedge gclk) begin
        if (push_ok) begin
            mem_data[wr_idx] <= spc_pcx_data_pa;
            mem_dest[wr_idx] <= cap_dest_q;
            mem_atom[wr_idx] <= cap_atom_q;
        end
    end

`ifdef IOP_PCX_ATOM_HOLD_EN
    // A dropped push right after a stored atomic first half means its partner is lost: release it alone.
    always_ff @(posedge gclk) begin
        if (push_ok) begin
            mem_rel[wr_idx] <= 1'b0;
        end else if (overflow && mem_atom[last_idx]) begin
            mem_rel[last_idx] <= 1'b1;
        end
    end
`endif

endmodule
